// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: FSM state
// encodings, opcode constants, immediate-format and ALU operation codes.
package mc_control_fsm_pkg;

    // FSM states; FETCH must stay at zero so a cleared register means FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    // Coarse ALU request from the FSM, refined by the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // Opcodes recognised by the control unit
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Immediate extender formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format for an opcode; unrecognised opcodes default to I-type
    function automatic logic [1:0] immFormat(input logic [6:0] op);
        logic [1:0] fmt;
        case (op)
            OP_LOAD,
            OP_ITYPE:  fmt = IMM_I;
            OP_STORE:  fmt = IMM_S;
            OP_BRANCH: fmt = IMM_B;
            OP_JAL:    fmt = IMM_J;
            default:   fmt = IMM_I;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: turns the FSM's coarse ALU request plus instruction fields
// into the concrete ALU operation code.
module alu_decoder
    import mc_control_fsm_pkg::*;
(
    input  aluop_e      aluop_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        opb5_i,
    output logic [2:0]  alucontrol_o
);

    // Subtraction is only an R-type form (op[5] set with funct7[5]); an
    // I-type addi with instr[30] set is still an add.
    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alucontrol_o = (opb5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol_o = ALU_SLT;
                    3'b110:  alucontrol_o = ALU_OR;
                    3'b111:  alucontrol_o = ALU_AND;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences each instruction through its
// fetch/decode/execute/memory/writeback states and drives the datapath.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pcwrite,
    output logic        adrsrc,
    output logic        memwrite,
    output logic        irwrite,
    output logic [1:0]  resultsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  immsrc,
    output logic [2:0]  alucontrol,
    output logic        regwrite
);

    state_e state_q;
    state_e state_d;

    logic   pcUpdate;
    logic   branch;
    aluop_e aluOp;
    logic   irWriteRaw;
    logic   memWriteRaw;
    logic   regWriteRaw;

    // State register; reset drops straight to FETCH without a clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and Moore outputs for the current state
    always_comb begin
        state_d     = S_FETCH;
        pcUpdate    = 1'b0;
        branch      = 1'b0;
        aluOp       = ALUOP_ADD;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        adrsrc      = 1'b0;
        resultsrc   = 2'b00;
        alusrca     = 2'b00;
        alusrcb     = 2'b00;

        case (state_q)
            S_FETCH: begin
                irWriteRaw = 1'b1;
                alusrcb    = 2'b10;
                resultsrc  = 2'b10;
                pcUpdate   = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECUTER;
                    OP_ITYPE:  state_d = S_EXECUTEI;
                    OP_JAL:    state_d = S_JAL;
                    OP_BRANCH: state_d = S_BEQ;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc   = 2'b01;
                regWriteRaw = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc      = 1'b1;
                memWriteRaw = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                aluOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regWriteRaw = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluOp   = ALUOP_SUB;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Write enables are held off while reset is asserted so an abandoned
    // instruction cannot commit anything.
    assign pcwrite  = reset_n & (pcUpdate | (branch & zero));
    assign irwrite  = reset_n & irWriteRaw;
    assign memwrite = reset_n & memWriteRaw;
    assign regwrite = reset_n & regWriteRaw;

    assign immsrc = immFormat(op);

    alu_decoder u_alu_decoder (
        .aluop_i      (aluOp),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .opb5_i       (op[5]),
        .alucontrol_o (alucontrol)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm: walks each instruction class
// through its state sequence and checks every control output per cycle.
module tb_mc_control_fsm;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
    logic       regwrite;

    int checks   = 0;
    int failures = 0;

    // Bench-local state numbering, used only to select expected outputs
    localparam logic [3:0] T_FETCH = 4'h0, T_DECODE = 4'h1, T_MEMADR = 4'h2,
                           T_MEMREAD = 4'h3, T_MEMWB = 4'h4, T_MEMWRITE = 4'h5,
                           T_EXR = 4'h6, T_EXI = 4'h7, T_ALUWB = 4'h8,
                           T_JAL = 4'h9, T_BEQ = 4'hA, T_RESET = 4'hF;

    mc_control_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .regwrite   (regwrite)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle: {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, regwrite}
    function automatic logic [10:0] observed();
        return {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, regwrite};
    endfunction

    // Hand-written expected bundle per state, same field order as observed()
    function automatic logic [10:0] expectedBundle(input logic [3:0] st, input logic z);
        logic [10:0] b;
        case (st)
            T_FETCH:    b = 11'b1_0_0_1_10_00_10_0;
            T_DECODE:   b = 11'b0_0_0_0_00_01_01_0;
            T_MEMADR:   b = 11'b0_0_0_0_00_10_01_0;
            T_MEMREAD:  b = 11'b0_1_0_0_00_00_00_0;
            T_MEMWB:    b = 11'b0_0_0_0_01_00_00_1;
            T_MEMWRITE: b = 11'b0_1_1_0_00_00_00_0;
            T_EXR:      b = 11'b0_0_0_0_00_10_00_0;
            T_EXI:      b = 11'b0_0_0_0_00_10_01_0;
            T_ALUWB:    b = 11'b0_0_0_0_00_00_00_1;
            T_JAL:      b = 11'b1_0_0_0_00_01_10_0;
            T_BEQ:      b = {z, 10'b0_0_0_00_10_00_0};
            default:    b = 11'b0_0_0_0_10_00_10_0;
        endcase
        return b;
    endfunction

    // Count one comparison and report it when it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    // Check the whole control bundle plus alucontrol and immsrc for one state
    task automatic checkState(input string name, input logic [3:0] st, input logic [2:0] expAlu, input logic [1:0] expImm);
        logic [2:0] alu;
        alu = (st == T_EXR || st == T_EXI) ? expAlu : (st == T_BEQ) ? 3'b001 : 3'b000;
        checkOutput($sformatf("%s.st%0d.ctl", name, st), 32'(observed()), 32'(expectedBundle(st, zero)));
        checkOutput($sformatf("%s.st%0d.alu", name, st), 32'(alucontrol), 32'(alu));
        checkOutput($sformatf("%s.st%0d.imm", name, st), 32'(immsrc), 32'(expImm));
    endtask

    // Run one instruction from FETCH; seq holds the following states as
    // nibbles (lowest first), ending with the FETCH that closes it.
    task automatic applyStimulus(input string name, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic [31:0] seq, input int len,
                                 input logic [2:0] expAlu, input logic [1:0] expImm);
        op       = opc;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        #1;
        checkState(name, T_FETCH, expAlu, expImm);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            #1;
            checkState(name, seq[4*i +: 4], expAlu, expImm);
        end
    endtask

    initial begin
        reset_n  = 1'b1;
        op       = 7'b0000000;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;

        // Asynchronous reset at power-up, held across a rising edge
        #1 reset_n = 1'b0;
        #1 checkState("reset", T_RESET, 3'b000, 2'b00);
        @(negedge clk);
        #1 checkState("reset_held", T_RESET, 3'b000, 2'b00);
        reset_n = 1'b1;

        // lw: 5 cycles
        applyStimulus("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 32'h00004321, 5, 3'b000, 2'b00);
        // sw: 4 cycles
        applyStimulus("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 32'h00000521, 4, 3'b000, 2'b01);
        // R-type sub/add/slt/or
        applyStimulus("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 32'h00000861, 4, 3'b001, 2'b00);
        applyStimulus("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 32'h00000861, 4, 3'b000, 2'b00);
        applyStimulus("slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 32'h00000861, 4, 3'b101, 2'b00);
        applyStimulus("or",    7'b0110011, 3'b110, 1'b0, 1'b0, 32'h00000861, 4, 3'b011, 2'b00);
        // I-type: instr[30] set must not turn addi into sub
        applyStimulus("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 32'h00000871, 4, 3'b000, 2'b00);
        applyStimulus("andi",  7'b0010011, 3'b111, 1'b0, 1'b0, 32'h00000871, 4, 3'b010, 2'b00);
        applyStimulus("xori",  7'b0010011, 3'b100, 1'b0, 1'b0, 32'h00000871, 4, 3'b000, 2'b00);
        // beq taken and not taken: 3 cycles
        applyStimulus("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 32'h000000A1, 3, 3'b000, 2'b10);
        applyStimulus("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 32'h000000A1, 3, 3'b000, 2'b10);
        // jal: 4 cycles
        applyStimulus("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 32'h00000891, 4, 3'b000, 2'b11);
        // unknown opcode skipped in 2 cycles
        applyStimulus("unk",   7'b1111111, 3'b000, 1'b0, 1'b0, 32'h00000001, 2, 3'b000, 2'b00);

        // Reset mid-MEMWRITE: walk sw up to MEMWRITE, then assert reset
        applyStimulus("sw_rst", 7'b0100011, 3'b010, 1'b0, 1'b0, 32'h00000521, 3, 3'b000, 2'b01);
        #2 reset_n = 1'b0;
        #1 checkState("midrst", T_RESET, 3'b000, 2'b01);
        @(negedge clk);
        #1 checkState("midrst_held", T_RESET, 3'b000, 2'b01);
        reset_n = 1'b1;
        #1 checkState("release", T_FETCH, 3'b000, 2'b01);
        @(negedge clk);
        #1 checkState("release", T_DECODE, 3'b000, 2'b01);
        @(negedge clk);
        #1 checkState("release", T_MEMADR, 3'b000, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
